systolic_feeder: RTL and testbench

//  Upstream stage of systolic_array: accepts one feature vector per beat (ROW lanes) over a

---
 rtl/systolic_feeder.sv | 103 ++++++++++
 tb/tb_systolic_feeder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_feeder
//  Function : Re-times one ROW-lane feature vector per beat into the diagonal
//             wavefront of systolic_array; pulses done once a tile is injected.
//  Revision : 1.0  initial release
// ============================================================================
module systolic_feeder #(
  parameter int WIDTH = 8,
  parameter int ROW   = 4
) (
  input  logic                 clk_in2,
  input  logic                 nrst_in2,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [ROW*WIDTH-1:0] s_data,
  input  logic                 s_last,
  output logic [ROW*WIDTH-1:0] feature_out,
  output logic [ROW-1:0]       in_en,
  output logic                 busy,
  output logic                 done
);

  localparam int                c_CNT_W      = $clog2(ROW) + 1;
  localparam logic [c_CNT_W-1:0] c_DRAIN_LOAD = c_CNT_W'(ROW - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_done;
  logic                w_accept;

  // Ready depends only on state and reset, never on s_valid.
  assign s_ready  = nrst_in2 & (r_state != S_DRAIN);
  assign w_accept = s_valid & s_ready;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;

  always_ff @(posedge clk_in2) begin
    if (!nrst_in2) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_STREAM: begin
          if (w_accept) begin
            if (s_last) begin
              r_state <= S_DRAIN;
              r_cnt   <= c_DRAIN_LOAD;
            end else begin
              r_state <= S_STREAM;
            end
          end
        end
        S_DRAIN: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Lane r is an (r+1)-deep chain; non-accept edges inject a zero bubble.
  for (genvar r = 0; r < ROW; r++) begin : g_lane
    logic [r:0][WIDTH-1:0] r_tap_d;
    logic [r:0]            r_tap_v;

    always_ff @(posedge clk_in2) begin
      if (!nrst_in2) begin
        r_tap_d <= '0;
        r_tap_v <= '0;
      end else begin
        r_tap_d[0] <= w_accept ? s_data[r*WIDTH +: WIDTH] : '0;
        r_tap_v[0] <= w_accept;
        for (int i = 1; i <= r; i++) begin
          r_tap_d[i] <= r_tap_d[i-1];
          r_tap_v[i] <= r_tap_v[i-1];
        end
      end
    end

    assign feature_out[r*WIDTH +: WIDTH] = r_tap_d[r];
    assign in_en[r]                      = r_tap_v[r];
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_feeder
//  Function : Scoreboard bench for systolic_feeder (directed tiles + random).
//  Revision : 1.0  initial release
// ============================================================================
module tb_systolic_feeder;
  localparam int WIDTH = 8;
  localparam int ROW   = 4;

  logic                 clk_in2  = 1'b0;
  logic                 nrst_in2 = 1'b0;
  logic                 s_valid  = 1'b0;
  logic                 s_last   = 1'b0;
  logic [ROW*WIDTH-1:0] s_data   = '0;
  logic                 s_ready;
  logic [ROW*WIDTH-1:0] feature_out;
  logic [ROW-1:0]       in_en;
  logic                 busy;
  logic                 done;

  systolic_feeder #(.WIDTH(WIDTH), .ROW(ROW)) dut (
    .clk_in2    (clk_in2),
    .nrst_in2   (nrst_in2),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .feature_out(feature_out),
    .in_en      (in_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_in2 = ~clk_in2;

  // Reference model: an accepted beat at edge E must appear on lane r after
  // edge E+r; a last beat at E closes input until E+ROW and fires done then.
  logic [WIDTH-1:0] lane_dq [ROW][$];
  int               lane_tq [ROW][$];
  int               done_q [$];
  int               edge_no    = 0;
  int               drain_end  = 0;
  bit               m_stream   = 1'b0;
  bit               acc        = 1'b0;
  bit               mon_en     = 1'b0;
  int               vectors    = 0;
  int               miscompares = 0;

  always @(posedge clk_in2) begin
    edge_no = edge_no + 1;
    acc     = 1'b0;
    if (!nrst_in2) begin
      for (int r = 0; r < ROW; r++) begin
        lane_dq[r].delete();
        lane_tq[r].delete();
      end
      done_q.delete();
      drain_end = 0;
      m_stream  = 1'b0;
    end else if (s_valid && s_ready) begin
      acc = 1'b1;
      for (int r = 0; r < ROW; r++) begin
        lane_dq[r].push_back(s_data[r*WIDTH +: WIDTH]);
        lane_tq[r].push_back(edge_no + r);
      end
      if (s_last) begin
        done_q.push_back(edge_no + ROW);
        drain_end = edge_no + ROW;
        m_stream  = 1'b0;
      end else begin
        m_stream = 1'b1;
      end
    end
    mon_en = 1'b1;
  end

  always @(negedge clk_in2) begin
    logic [WIDTH-1:0] got;
    logic [WIDTH-1:0] expd;
    bit               due;
    bit               exp_done;
    bit               exp_ready;
    bit               exp_busy;
    if (mon_en) begin
      for (int r = 0; r < ROW; r++) begin
        got = feature_out[r*WIDTH +: WIDTH];
        due = (lane_tq[r].size() > 0) && (lane_tq[r][0] == edge_no);
        vectors++;
        if (due) begin
          expd = lane_dq[r].pop_front();
          void'(lane_tq[r].pop_front());
          if (in_en[r] !== 1'b1 || got !== expd) begin
            miscompares++;
            $display("FAIL lane%0d edge %0d: got in_en=%b data=%h, want in_en=1 data=%h",
                     r, edge_no, in_en[r], got, expd);
          end
        end else if (in_en[r] !== 1'b0 || got !== '0) begin
          miscompares++;
          $display("FAIL lane%0d_idle edge %0d: got in_en=%b data=%h, want in_en=0 data=00",
                   r, edge_no, in_en[r], got);
        end
      end
      exp_done = (done_q.size() > 0) && (done_q[0] == edge_no);
      if (exp_done) void'(done_q.pop_front());
      vectors++;
      if (done !== exp_done) begin
        miscompares++;
        $display("FAIL done edge %0d: got %b, want %b", edge_no, done, exp_done);
      end
      exp_ready = nrst_in2 && !(edge_no < drain_end);
      exp_busy  = m_stream || (edge_no < drain_end);
      vectors++;
      if (s_ready !== exp_ready || busy !== exp_busy) begin
        miscompares++;
        $display("FAIL ready_busy edge %0d: got ready=%b busy=%b, want ready=%b busy=%b",
                 edge_no, s_ready, busy, exp_ready, exp_busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in2);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) tick();
  endtask

  // Offers one beat and holds it until accepted (bounded wait).
  task automatic send_beat(input logic [ROW*WIDTH-1:0] d, input logic last);
    int waited;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    waited  = 0;
    tick();
    while (!acc && waited < 50) begin
      tick();
      waited++;
    end
    if (!acc) begin
      miscompares++;
      $display("FAIL accept_timeout edge %0d: got no accept, want accept within 50 cycles", edge_no);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  function automatic logic [ROW*WIDTH-1:0] rnd_vec();
    logic [ROW*WIDTH-1:0] v;
    for (int r = 0; r < ROW; r++) v[r*WIDTH +: WIDTH] = WIDTH'($urandom_range(1, 255));
    return v;
  endfunction

  initial begin
    // Reset held with an offered beat: nothing may be accepted.
    nrst_in2 = 1'b0;
    s_valid  = 1'b1;
    s_data   = rnd_vec();
    s_last   = 1'b1;
    repeat (3) tick();
    nrst_in2 = 1'b1;
    idle(2);

    send_beat({8'h04, 8'h03, 8'h02, 8'h01}, 1'b1);
    idle(6);

    send_beat(rnd_vec(), 1'b0);
    send_beat(rnd_vec(), 1'b0);
    send_beat(rnd_vec(), 1'b1);
    idle(6);

    send_beat(rnd_vec(), 1'b0);
    idle(2);
    send_beat(rnd_vec(), 1'b1);
    idle(6);

    // Reset right after lane 1 has emitted its first beat.
    send_beat(rnd_vec(), 1'b0);
    tick();
    nrst_in2 = 1'b0;
    tick();
    nrst_in2 = 1'b1;
    idle(6);
    send_beat({8'h04, 8'h03, 8'h02, 8'h01}, 1'b1);
    idle(6);

    // Back-to-back tiles: second beat held off through DRAIN.
    send_beat(rnd_vec(), 1'b1);
    send_beat(rnd_vec(), 1'b1);
    idle(6);

    // Random traffic with held beats and occasional resets.
    s_valid = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!(s_valid && !acc)) begin
        s_valid = ($urandom_range(0, 2) != 0);
        s_data  = rnd_vec();
        s_last  = ($urandom_range(0, 3) == 0);
      end
      nrst_in2 = ($urandom_range(0, 99) != 0);
      tick();
    end
    nrst_in2 = 1'b1;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
